// File: rtl/mini_alu_pkg.sv
// Shared types for the mini_alu_seq block: operation codes and controller states.
package mini_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_SHL = 3'd2,
    OP_SRA = 3'd3,
    OP_MUL = 3'd4
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mini_alu_mul.sv
// Iterative shift-add multiplier: operands load on start, one partial-product step per cycle.
module mini_alu_mul #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  import mini_alu_pkg::*;

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  logic [RW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    step_acc;

  assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = RW'(a);
      mplier_d = b;
      cnt_d    = CNT_INIT;
    end else if (cnt_q != '0) begin
      acc_d    = step_acc;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_LAST;
    end
  end

  // The final step's sum is exposed combinationally so the owner can register it on that same edge.
  assign done    = (cnt_q == CNT_LAST);
  assign product = step_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mini_alu_seq.sv
// Sequential mini ALU: single-cycle ADD/SUB/SHL/SRA, WIDTH-cycle MUL, valid/ready on both sides.
// in_valid/in_ready: a command transfers on a rising edge where both are 1; out_valid/out_ready likewise for results.
module mini_alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     op1,
  input  logic [WIDTH-1:0]     op2,
  input  logic [2:0]           opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   res,
  output logic                 err
);
  import mini_alu_pkg::*;

  localparam int RW = 2 * WIDTH;
  localparam int SW = $clog2(RW);

  state_e           state_q, state_d;
  logic [RW-1:0]    res_q, res_d;
  logic             err_q, err_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [RW-1:0]    alu_res;
  logic             alu_err;
  logic [RW-1:0]    op1_ext;
  logic [RW-1:0]    op1_sext;
  logic [31:0]      shamt;

  logic             mul_start;
  logic             mul_done;
  logic [RW-1:0]    mul_product;

  mini_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (op1),
    .b       (op2),
    .done    (mul_done),
    .product (mul_product)
  );

  assign op1_ext  = RW'(op1);
  assign op1_sext = {{WIDTH{op1[WIDTH-1]}}, op1};
  assign shamt    = 32'(op2);

  // Single-cycle results come straight from the command being accepted and land in res_q on that edge.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (opcode_e'(opcode))
      OP_ADD: alu_res = op1_ext + RW'(op2);
      OP_SUB: alu_res = op1_ext - RW'(op2);
      OP_SHL: alu_res = (shamt >= RW) ? '0 : (op1_ext << op2[SW-1:0]);
      OP_SRA: alu_res = (shamt >= WIDTH) ? {RW{op1[WIDTH-1]}}
                                         : RW'($signed(op1_sext) >>> op2[SW-1:0]);
      OP_MUL: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    err_d     = err_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (opcode_e'(opcode) == OP_MUL) begin
            mul_start = 1'b1;
            err_d     = 1'b0;
            state_d   = ST_BUSY;
          end else begin
            res_d   = alu_res;
            err_d   = alu_err;
            state_d = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (mul_done) begin
          res_d   = mul_product;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      res_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mini_alu_seq.sv
// Directed bench for mini_alu_seq: a WIDTH=4 instance for most scenarios plus a WIDTH=8 multiply instance.
module tb_mini_alu_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op1 = '0;
  logic [3:0] op2 = '0;
  logic [2:0] opcode = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] res;
  logic       err;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [7:0]  op1_8 = '0;
  logic [7:0]  op2_8 = '0;
  logic [2:0]  opcode8 = '0;
  logic        out_valid8;
  logic        out_ready8 = 1'b0;
  logic [15:0] res8;
  logic        err8;

  int check_cnt = 0;
  int pass_cnt  = 0;

  mini_alu_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .opcode(opcode), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .err(err)
  );

  mini_alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .op1(op1_8), .op2(op2_8), .opcode(opcode8), .out_valid(out_valid8),
    .out_ready(out_ready8), .res(res8), .err(err8)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drivers: offer one command for one edge, then scramble operands
  task automatic issue(input logic [2:0] opc, input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    opcode   = opc;
    op1      = a;
    op2      = b;
    tick();
    in_valid = 1'b0;
    op1      = 4'($urandom_range(0, 15));
    op2      = 4'($urandom_range(0, 15));
    opcode   = 3'($urandom_range(0, 7));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_cnt++;
    if ({in_ready, out_valid, res, err} !== {1'b1, 1'b0, 8'h00, 1'b0})
      $display("FAIL reset_state: rdy=%b vld=%b res=%h err=%b, want rdy=1 vld=0 res=00 err=0",
               in_ready, out_valid, res, err);
    else pass_cnt++;
  endtask

  task automatic test_add();
    issue(3'd0, 4'd15, 4'd15);
    check_cnt++;
    if ({out_valid, res, err} !== {1'b1, 8'h1E, 1'b0})
      $display("FAIL add_15_15: vld=%b res=%h err=%b, want vld=1 res=1e err=0", out_valid, res, err);
    else pass_cnt++;
    drain();
    check_cnt++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL add_drain: rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_single_cycle();
    logic [2:0] t_op[10];
    logic [3:0] t_a[10];
    logic [3:0] t_b[10];
    logic [7:0] t_res[10];
    t_op  = '{3'd1,  3'd3,  3'd3,  3'd3,  3'd2,  3'd2,  3'd2,  3'd2,  3'd1,  3'd0};
    t_a   = '{4'd3,  4'h8,  4'h8,  4'h6,  4'hF,  4'hF,  4'h1,  4'h5,  4'd9,  4'd7};
    t_b   = '{4'd5,  4'd2,  4'd9,  4'd1,  4'd4,  4'd8,  4'd7,  4'd0,  4'd4,  4'd8};
    t_res = '{8'hFE, 8'hFE, 8'hFF, 8'h03, 8'hF0, 8'h00, 8'h80, 8'h05, 8'h05, 8'h0F};
    for (int i = 0; i < 10; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      check_cnt++;
      if ({out_valid, res, err} !== {1'b1, t_res[i], 1'b0})
        $display("FAIL alu_vec%0d op=%0d a=%h b=%h: vld=%b res=%h err=%b, want vld=1 res=%h err=0",
                 i, t_op[i], t_a[i], t_b[i], out_valid, res, err, t_res[i]);
      else pass_cnt++;
      drain();
    end
  endtask

  task automatic test_mul();
    logic [3:0] t_a[3];
    logic [3:0] t_b[3];
    logic [7:0] t_res[3];
    t_a   = '{4'd13, 4'd15, 4'd0};
    t_b   = '{4'd11, 4'd15, 4'd9};
    t_res = '{8'h8F, 8'hE1, 8'h00};
    for (int k = 0; k < 3; k++) begin
      issue(3'd4, t_a[k], t_b[k]);
      for (int c = 1; c <= 4; c++) begin
        check_cnt++;
        if ({in_ready, out_valid} !== 2'b00)
          $display("FAIL mul%0d_busy_c%0d: rdy=%b vld=%b, want rdy=0 vld=0", k, c, in_ready, out_valid);
        else pass_cnt++;
        // a command offered while busy must be dropped, not queued
        in_valid = (c == 2 || c == 3);
        opcode   = 3'd0;
        op1      = 4'd1;
        op2      = 4'd1;
        tick();
      end
      in_valid = 1'b0;
      check_cnt++;
      if ({out_valid, res, err} !== {1'b1, t_res[k], 1'b0})
        $display("FAIL mul%0d_result: vld=%b res=%h err=%b, want vld=1 res=%h err=0",
                 k, out_valid, res, err, t_res[k]);
      else pass_cnt++;
      drain();
      tick();
      check_cnt++;
      if ({in_ready, out_valid} !== 2'b10)
        $display("FAIL mul%0d_no_queue: rdy=%b vld=%b, want rdy=1 vld=0", k, in_ready, out_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_mul8();
    logic [7:0]  t_a[2];
    logic [7:0]  t_b[2];
    logic [15:0] t_res[2];
    t_a   = '{8'd255, 8'd200};
    t_b   = '{8'd255, 8'd3};
    t_res = '{16'hFE01, 16'h0258};
    for (int k = 0; k < 2; k++) begin
      in_valid8 = 1'b1;
      opcode8   = 3'd4;
      op1_8     = t_a[k];
      op2_8     = t_b[k];
      tick();
      in_valid8 = 1'b0;
      op1_8     = 8'h00;
      op2_8     = 8'h00;
      for (int c = 1; c <= 8; c++) begin
        if (c == 8) begin
          check_cnt++;
          if ({in_ready8, out_valid8} !== 2'b00)
            $display("FAIL mul8_%0d_busy: rdy=%b vld=%b, want rdy=0 vld=0", k, in_ready8, out_valid8);
          else pass_cnt++;
        end
        tick();
      end
      check_cnt++;
      if ({out_valid8, res8, err8} !== {1'b1, t_res[k], 1'b0})
        $display("FAIL mul8_%0d_result: vld=%b res=%h err=%b, want vld=1 res=%h err=0",
                 k, out_valid8, res8, err8, t_res[k]);
      else pass_cnt++;
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    issue(3'd0, 4'd1, 4'd2);
    for (int c = 0; c < 10; c++) begin
      if ({out_valid, in_ready, res, err} !== {1'b1, 1'b0, 8'h03, 1'b0}) bad++;
      in_valid = (c == 3);
      opcode   = 3'd0;
      op1      = 4'd5;
      op2      = 4'd5;
      tick();
    end
    in_valid = 1'b0;
    check_cnt++;
    if ({out_valid, res} !== {1'b1, 8'h03} || bad != 0)
      $display("FAIL backpressure_hold: bad_cycles=%0d vld=%b res=%h, want bad_cycles=0 vld=1 res=03",
               bad, out_valid, res);
    else pass_cnt++;
    drain();
    check_cnt++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL backpressure_exit: rdy=%b vld=%b, want rdy=1 vld=0", in_ready, out_valid);
    else pass_cnt++;
    tick();
    tick();
    check_cnt++;
    if (out_valid !== 1'b0)
      $display("FAIL backpressure_pulse_dropped: vld=%b, want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_busy();
    issue(3'd4, 4'd13, 4'd11);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cnt++;
    if ({in_ready, out_valid, res} !== {1'b1, 1'b0, 8'h00})
      $display("FAIL reset_mid_mul: rdy=%b vld=%b res=%h, want rdy=1 vld=0 res=00", in_ready, out_valid, res);
    else pass_cnt++;
    for (int c = 0; c < 6; c++) tick();
    check_cnt++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_mid_mul_no_result: vld=%b, want 0", out_valid);
    else pass_cnt++;
    issue(3'd0, 4'd2, 4'd2);
    check_cnt++;
    if ({out_valid, res, err} !== {1'b1, 8'h04, 1'b0})
      $display("FAIL after_reset_add: vld=%b res=%h err=%b, want vld=1 res=04 err=0", out_valid, res, err);
    else pass_cnt++;
    // reset while DONE waits, with out_ready raised on the same edge
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    check_cnt++;
    if ({in_ready, out_valid, res, err} !== {1'b1, 1'b0, 8'h00, 1'b0})
      $display("FAIL reset_in_done: rdy=%b vld=%b res=%h err=%b, want rdy=1 vld=0 res=00 err=0",
               in_ready, out_valid, res, err);
    else pass_cnt++;
    // reset beats a simultaneous command
    rst      = 1'b1;
    in_valid = 1'b1;
    opcode   = 3'd0;
    op1      = 4'd7;
    op2      = 4'd7;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check_cnt++;
    if ({in_ready, out_valid, res} !== {1'b1, 1'b0, 8'h00})
      $display("FAIL reset_vs_in_valid: rdy=%b vld=%b res=%h, want rdy=1 vld=0 res=00", in_ready, out_valid, res);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    logic [2:0] t_op[3];
    t_op = '{3'd6, 3'd5, 3'd7};
    for (int i = 0; i < 3; i++) begin
      issue(3'd0, 4'd9, 4'd9);
      drain();
      issue(t_op[i], 4'd3, 4'd4);
      check_cnt++;
      if ({out_valid, res, err} !== {1'b1, 8'h00, 1'b1})
        $display("FAIL illegal_op%0d: vld=%b res=%h err=%b, want vld=1 res=00 err=1",
                 t_op[i], out_valid, res, err);
      else pass_cnt++;
      drain();
    end
    issue(3'd1, 4'd9, 4'd4);
    check_cnt++;
    if ({out_valid, res, err} !== {1'b1, 8'h05, 1'b0})
      $display("FAIL err_clears: vld=%b res=%h err=%b, want vld=1 res=05 err=0", out_valid, res, err);
    else pass_cnt++;
    drain();
  endtask

  initial begin
    test_reset();
    test_add();
    test_single_cycle();
    test_mul();
    test_mul8();
    test_backpressure();
    test_reset_busy();
    test_illegal();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
